// File: rtl/filter_output_arbiter_if.sv
// Handshake bundle between the per-filter pair buffers and the output arbiter.
// The master modport is the buffer/downstream side; the slave modport is the arbiter.
interface filter_output_arbiter_if #(
    parameter int NUM_FILTERS = 7,
    parameter int CREDITS     = 8
);
    localparam int CW = $clog2(CREDITS + 1);

    logic [NUM_FILTERS-1:0] i_filter_buffer_empty;
    logic                   i_credit_return;
    logic                   i_flush;
    logic [NUM_FILTERS-1:0] o_filter_buffer_rd_en;
    logic [NUM_FILTERS-1:0] o_filter_output_arb_result;
    logic [NUM_FILTERS-1:0] o_filter_buffer_readout_valid;
    logic [CW-1:0]          o_credit_count;
    logic                   o_idle;

    modport master (
        output i_filter_buffer_empty,
        output i_credit_return,
        output i_flush,
        input  o_filter_buffer_rd_en,
        input  o_filter_output_arb_result,
        input  o_filter_buffer_readout_valid,
        input  o_credit_count,
        input  o_idle
    );

    modport slave (
        input  i_filter_buffer_empty,
        input  i_credit_return,
        input  i_flush,
        output o_filter_buffer_rd_en,
        output o_filter_output_arb_result,
        output o_filter_buffer_readout_valid,
        output o_credit_count,
        output o_idle
    );
endinterface

// File: rtl/filter_output_arbiter.sv
// Credit-throttled round-robin arbiter draining the filter pair buffers into pair-select.
// Read enable is combinational; the grant is re-presented one cycle later aligned with buffer data.
module filter_output_arbiter #(
    parameter int NUM_FILTERS = 7,
    parameter int CREDITS     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    filter_output_arbiter_if.slave bus
);
    localparam int PW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int CW = $clog2(CREDITS + 1);

    localparam logic [PW:0]   NF_EXT   = (PW + 1)'(NUM_FILTERS);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_FILTERS - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);

    logic [PW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          credits_q, credits_d;
    logic [NUM_FILTERS-1:0] result_q;
    logic                   idle_q, idle_d;

    logic [NUM_FILTERS-1:0] req;
    logic                   issue_ok;
    logic                   found;
    logic [PW-1:0]          gidx;
    logic [PW:0]            probe;
    logic [NUM_FILTERS-1:0] rd_en;

    assign req      = ~bus.i_filter_buffer_empty;
    assign issue_ok = (credits_q != '0) && !bus.i_flush && rst_n;

    // First requester at or after ptr_q, wrapping past the last filter.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        probe = '0;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            probe = {1'b0, ptr_q} + (PW + 1)'(i);
            if (probe >= NF_EXT) begin
                probe = probe - NF_EXT;
            end
            if (!found && issue_ok && req[probe[PW-1:0]]) begin
                found = 1'b1;
                gidx  = probe[PW-1:0];
            end
        end
    end

    always_comb begin
        rd_en = '0;
        ptr_d = ptr_q;
        if (found) begin
            rd_en[gidx] = 1'b1;
            ptr_d       = (gidx == PTR_LAST) ? '0 : gidx + PTR_ONE;
        end
    end

    // A grant and a return in the same cycle cancel; returns beyond full are dropped.
    always_comb begin
        credits_d = credits_q;
        case ({found, bus.i_credit_return})
            2'b10:   credits_d = credits_q - CRED_ONE;
            2'b01:   credits_d = (credits_q == CRED_MAX) ? credits_q : credits_q + CRED_ONE;
            default: credits_d = credits_q;
        endcase
    end

    assign idle_d = (&bus.i_filter_buffer_empty) && (result_q == '0) && (credits_q == CRED_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            credits_q <= CRED_MAX;
            result_q  <= '0;
            idle_q    <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            result_q  <= rd_en;
            idle_q    <= idle_d;
        end
    end

    assign bus.o_filter_buffer_rd_en         = rd_en;
    assign bus.o_filter_output_arb_result    = result_q;
    assign bus.o_filter_buffer_readout_valid = result_q;
    assign bus.o_credit_count                = credits_q;
    assign bus.o_idle                        = idle_q;
endmodule

// File: tb/tb_filter_output_arbiter.sv
// Directed scoreboard bench for filter_output_arbiter with 4 filters and 8 credits.
module tb_filter_output_arbiter;
    localparam int NF = 4;
    localparam int NC = 8;

    logic clk = 1'b0;
    logic rst_n;

    filter_output_arbiter_if #(.NUM_FILTERS(NF), .CREDITS(NC)) bus ();

    filter_output_arbiter #(.NUM_FILTERS(NF), .CREDITS(NC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: buffer occupancy, round-robin pointer, credits.
    int         m_cnt [NF];
    int         m_ptr;
    int         m_cred;
    logic [3:0] sb [$];
    logic [3:0] last_rd;
    logic [3:0] last_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_grant(input logic fl);
        logic [3:0] g;
        int         idx;
        g = 4'b0000;
        if (m_cred > 0 && !fl) begin
            for (int k = 0; k < NF; k++) begin
                idx = (m_ptr + k) % NF;
                if (g == 4'b0000 && m_cnt[idx] > 0) g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic drive_empty();
        for (int i = 0; i < NF; i++) bus.i_filter_buffer_empty[i] = (m_cnt[i] == 0);
    endtask

    // Starts and ends at a falling edge; one rising edge in between.
    task automatic tick(input logic ret, input logic fl);
        logic [3:0] eg;
        logic [3:0] er;
        bus.i_credit_return = ret;
        bus.i_flush         = fl;
        drive_empty();
        #1;
        er = (sb.size() > 0) ? sb.pop_front() : 4'b0000;
        last_res = bus.o_filter_output_arb_result;
        last_rd  = bus.o_filter_buffer_rd_en;
        check("arb_result", 32'(bus.o_filter_output_arb_result), 32'(er));
        check("readout_valid", 32'(bus.o_filter_buffer_readout_valid), 32'(er));
        check("credit_count", 32'(bus.o_credit_count), 32'(m_cred));
        eg = model_grant(fl);
        check("rd_en", 32'(bus.o_filter_buffer_rd_en), 32'(eg));
        sb.push_back(eg);
        @(posedge clk);
        for (int i = 0; i < NF; i++) begin
            if (eg[i]) begin
                m_cnt[i]--;
                m_ptr = (i + 1) % NF;
            end
        end
        if (eg != 4'b0000 && !ret) m_cred--;
        else if (eg == 4'b0000 && ret && m_cred < NC) m_cred++;
        @(negedge clk);
        bus.i_credit_return = 1'b0;
        bus.i_flush         = 1'b0;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_cred = NC;
        sb.delete();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < NF; i++) m_cnt[i] = 0;
        drive_empty();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_credit_return = 1'b0;
        bus.i_flush         = 1'b0;
        for (int i = 0; i < NF; i++) m_cnt[i] = 1;
        drive_empty();
        model_reset();
        @(negedge clk);
        #1;
        check("reset_rd_en", 32'(bus.o_filter_buffer_rd_en), 32'h0);
        check("reset_arb_result", 32'(bus.o_filter_output_arb_result), 32'h0);
        check("reset_readout_valid", 32'(bus.o_filter_buffer_readout_valid), 32'h0);
        check("reset_credits", 32'(bus.o_credit_count), 32'd8);
        check("reset_idle", 32'(bus.o_idle), 32'h0);
        for (int i = 0; i < NF; i++) m_cnt[i] = 0;
        drive_empty();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", 32'(bus.o_idle), 32'h1);

        // All four buffers hold 3 entries, no returns: eight grants then credit starvation.
        for (int i = 0; i < NF; i++) m_cnt[i] = 3;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0);
            check("rr_sequence", 32'(last_rd), (k < 8) ? (32'h1 << (k % 4)) : 32'h0);
        end
        check("credits_exhausted", 32'(bus.o_credit_count), 32'd0);

        // Single busy buffer with a return every cycle.
        do_reset();
        m_cnt[2] = 5;
        for (int k = 0; k < 7; k++) begin
            tick(1'b1, 1'b0);
            check("single_buf", 32'(last_rd), (k < 5) ? 32'h4 : 32'h0);
        end
        check("single_buf_credits", 32'(bus.o_credit_count), 32'd8);
        m_cnt[0] = 1; m_cnt[1] = 1; m_cnt[3] = 1;
        tick(1'b0, 1'b0);
        check("ptr_after_single", 32'(last_rd), 32'h8);

        // Last credit: grant 0, stall, return at cycle 4, grant 3 at cycle 5.
        do_reset();
        m_cnt[3] = 7;
        for (int k = 0; k < 7; k++) tick(1'b0, 1'b0);
        check("one_credit_left", 32'(bus.o_credit_count), 32'd1);
        m_cnt[0] = 1; m_cnt[3] = 1;
        for (int k = 0; k < 6; k++) begin
            tick((k == 4) ? 1'b1 : 1'b0, 1'b0);
            check("credit_stall", 32'(last_rd), (k == 0) ? 32'h1 : (k == 5) ? 32'h8 : 32'h0);
        end

        // Simultaneous grant and return; saturation at full.
        do_reset();
        m_cnt[1] = 3;
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
        m_cnt[2] = 1;
        tick(1'b1, 1'b0);
        check("grant_and_return", 32'(bus.o_credit_count), 32'd5);
        for (int k = 0; k < 6; k++) tick(1'b1, 1'b0);
        check("credit_saturate", 32'(bus.o_credit_count), 32'd8);

        // Flush blocks new grants but not the in-flight result.
        do_reset();
        m_cnt[1] = 3;
        tick(1'b0, 1'b0);
        check("flush_pre_grant", 32'(last_rd), 32'h2);
        tick(1'b0, 1'b1);
        check("flush_inflight", 32'(last_res), 32'h2);
        check("flush_block", 32'(last_rd), 32'h0);
        tick(1'b1, 1'b1);
        check("flush_block2", 32'(last_rd), 32'h0);
        tick(1'b0, 1'b0);
        check("flush_release", 32'(last_rd), 32'h2);

        // Asynchronous reset between edges while a grant is in flight.
        do_reset();
        for (int i = 0; i < NF; i++) m_cnt[i] = 2;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_arb_result", 32'(bus.o_filter_output_arb_result), 32'h0);
        check("async_readout_valid", 32'(bus.o_filter_buffer_readout_valid), 32'h0);
        check("async_credits", 32'(bus.o_credit_count), 32'd8);
        check("async_rd_en", 32'(bus.o_filter_buffer_rd_en), 32'h0);
        model_reset();
        for (int i = 0; i < NF; i++) m_cnt[i] = 0;
        drive_empty();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b0);
        check("idle_after_async", 32'(bus.o_idle), 32'h1);
        m_cnt[1] = 1; m_cnt[2] = 1;
        tick(1'b0, 1'b0);
        check("ptr_after_async", 32'(last_rd), 32'h2);
        check("busy_not_idle", 32'(bus.o_idle), 32'h0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
